trap_ctrl: RTL
==============

Name: trap_ctrl

Overview:
- Machine-mode trap sequencer sitting directly upstream of the machine CSR file.
- Collects exception requests from the pipeline and the CSR file's illegal-access flag, prioritises them, and computes mepc/mcause/mtval/mstatus updates.
- Drives the CSR file's trap_taken/trap_done strobes, redirects the PC to the trap vector or to mepc, and owns the current privilege level register.

Parameters:
- XLEN, 64, datapath width
- RESET_PRIV, 2'b11, privilege level after reset (M)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- instr_valid  in  1  instruction in execute is valid; qualifies all event inputs
- pc_addr  in  XLEN  PC of the instruction in execute
- exc_en  in  1  CSR file illegal-access flag
- exc_code  in  4  CSR file cause code
- exc_val  in  XLEN  CSR file tval value
- fetch_misaligned  in  1  instruction address misaligned
- illegal_instr  in  1  decode illegal instruction
- instr_bits  in  32  raw instruction word
- is_ebreak  in  1  EBREAK instruction
- is_ecall  in  1  ECALL instruction
- is_mret  in  1  MRET instruction
- ld_misaligned  in  1  load address misaligned
- st_misaligned  in  1  store address misaligned
- mem_addr  in  XLEN  effective load/store address
- mstatus_current  in  XLEN  mstatus from the CSR file
- mtvec_trap  in  XLEN  mtvec from the CSR file; valid the cycle after trap_taken
- mepc_current, mcause_current, mtval_current  in  XLEN each  current CSR values
- trap_taken  out  1  one-cycle trap-entry strobe
- trap_done  out  1  one-cycle MRET strobe
- mepc_next, mcause_next, mtval_next, mstatus_next  out  XLEN each  CSR update values
- pc_redirect_en  out  1  load pc_redirect into the PC
- pc_redirect  out  XLEN  redirect target
- flush  out  1  kill younger instructions
- busy  out  1  stall the pipeline; events ignored while high
- priv_lvl  out  2  current privilege (0 = U, 3 = M)

Behaviour:
- Reset (rst low, asynchronous): state IDLE, priv_lvl = RESET_PRIV, every other output 0.
- States: IDLE, ENTER, REDIRECT, RETURN.
- IDLE: events are sampled only when instr_valid is high and busy is low.
- Exception priority, highest first. The first true source is captured into internal registers at the clock edge:
  - fetch_misaligned: cause 0, tval = pc_addr
  - illegal_instr: cause 2, tval = zero-extended instr_bits
  - exc_en: cause zero-extended exc_code, tval = exc_val
  - MRET at priv_lvl < 3: cause 2, tval = instr_bits
  - is_ebreak: cause 3, tval = pc_addr
  - is_ecall: cause 8 + priv_lvl (8 = U, 11 = M), tval = 0
  - ld_misaligned: cause 4, tval = mem_addr
  - st_misaligned: cause 6, tval = mem_addr
- Any exception: IDLE -> ENTER.
- is_mret at priv_lvl = 3 with no exception: IDLE -> RETURN.
- Exception and MRET in the same cycle: exception wins.
- ENTER (one cycle):
  - trap_taken = 1, flush = 1, busy = 1.
  - mepc_next = captured pc with bits [1:0] forced to 0; mcause_next = captured cause (bit 63 = 0, no interrupts); mtval_next = captured tval.
  - mstatus_next = mstatus_current with MPIE[7] = MIE[3], MIE[3] = 0, MPP[12:11] = priv_lvl.
  - priv_lvl <= 3 at the end of the cycle. Next state REDIRECT.
- REDIRECT (one cycle): pc_redirect_en = 1, pc_redirect = {mtvec_trap[63:2], 2'b00} (direct mode only), busy = 1. Next state IDLE.
- RETURN (one cycle):
  - trap_done = 1, flush = 1, busy = 1, pc_redirect_en = 1, pc_redirect = {mepc_current[63:2], 2'b00}.
  - mepc_next, mcause_next and mtval_next equal the *_current inputs, so the CSR file does not corrupt them.
  - mstatus_next = mstatus_current with MIE = MPIE, MPIE = 1, MPP = 0.
  - priv_lvl <= mstatus_current[12:11], with 2'b10 mapped to 0. Next state IDLE.
- Latency: exception sampled at edge N -> trap_taken during cycle N+1 -> redirect during N+2. MRET: trap_done and redirect during N+1.
- Strobe and CSR outputs are 0 in IDLE. Outputs are driven from registered state; no combinational input-to-output path except the mtvec_trap/mepc_current/mstatus_current muxing.
- Reset mid-sequence: aborts immediately to IDLE; no strobe is emitted afterwards.

Decomposition:
- Shared package: cause code constants, mstatus bit positions (MIE, MPIE, MPP), privilege encodings, state enum.
- One natural sub-module: trap_prio_enc (combinational priority encoder producing valid, cause and tval).

Test Plan:
- Reset, then ECALL at priv 3, pc 0x100, mtvec 0x8000_0001, mstatus 0x8 -> N+1: trap_taken, mepc_next 0x100, mcause_next 11, mstatus_next 0x1880 (MPIE = 1, MIE = 0, MPP = 3); N+2: pc_redirect 0x8000_0000.
- MRET at priv 3 with mstatus 0x80 (MPP = 0) and mepc 0x204 -> trap_done, pc_redirect 0x204, mstatus_next 0x88, mepc/mcause/mtval unchanged, priv_lvl becomes 0.
- At priv 0: ECALL -> mcause 8, priv back to 3; separately MRET at priv 0 -> mcause 2, no trap_done.
- Illegal instruction plus load misaligned (mem_addr 0x1003) in the same cycle -> mcause 2, mtval = instr_bits. Load misaligned alone -> mcause 4, mtval 0x1003.
- exc_en with code 2 and exc_val 0xF15, and is_mret in the same cycle -> trap entry with mtval 0xF15, no trap_done. An event presented while busy is ignored.
- rst asserted during ENTER -> outputs 0 and priv_lvl 3 immediately; no REDIRECT follows release.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer.
// Cause codes, mstatus field positions, privilege levels, FSM states.
package trap_ctrl_pkg;

    localparam logic [3:0] CAUSE_FETCH_MIS = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
    localparam logic [3:0] CAUSE_BREAK     = 4'd3;
    localparam logic [3:0] CAUSE_LD_MIS    = 4'd4;
    localparam logic [3:0] CAUSE_ST_MIS    = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_U   = 4'd8;

    localparam int MS_MIE   = 3;
    localparam int MS_MPIE  = 7;
    localparam int MS_MPP_L = 11;
    localparam int MS_MPP_H = 12;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTER,
        ST_REDIRECT,
        ST_RETURN
    } state_e;

endpackage

// File: rtl/trap_ctrl_prio.sv
// Combinational exception priority encoder.
// Picks the highest-priority exception source and its cause/tval.
module trap_prio_enc
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]      i_priv,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_exc_en,
    input  logic [3:0]      i_exc_code,
    input  logic [XLEN-1:0] i_exc_val,
    input  logic            i_fetch_mis,
    input  logic            i_illegal,
    input  logic [31:0]     i_instr_bits,
    input  logic            i_ebreak,
    input  logic            i_ecall,
    input  logic            i_mret,
    input  logic            i_ld_mis,
    input  logic            i_st_mis,
    input  logic [XLEN-1:0] i_mem_addr,
    output logic            o_valid,
    output logic [3:0]      o_cause,
    output logic [XLEN-1:0] o_tval
);

    logic [XLEN-1:0] w_instr_ext;

    assign w_instr_ext = {{(XLEN-32){1'b0}}, i_instr_bits};

    always_comb begin
        o_valid = 1'b1;
        o_cause = '0;
        o_tval  = '0;
        if (i_fetch_mis) begin
            o_cause = CAUSE_FETCH_MIS;
            o_tval  = i_pc;
        end else if (i_illegal) begin
            o_cause = CAUSE_ILLEGAL;
            o_tval  = w_instr_ext;
        end else if (i_exc_en) begin
            o_cause = i_exc_code;
            o_tval  = i_exc_val;
        end else if (i_mret && (i_priv != PRIV_M)) begin
            // MRET below M-mode is an illegal instruction
            o_cause = CAUSE_ILLEGAL;
            o_tval  = w_instr_ext;
        end else if (i_ebreak) begin
            o_cause = CAUSE_BREAK;
            o_tval  = i_pc;
        end else if (i_ecall) begin
            o_cause = CAUSE_ECALL_U + {2'b00, i_priv};
        end else if (i_ld_mis) begin
            o_cause = CAUSE_LD_MIS;
            o_tval  = i_mem_addr;
        end else if (i_st_mis) begin
            o_cause = CAUSE_ST_MIS;
            o_tval  = i_mem_addr;
        end else begin
            o_valid = 1'b0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: entry/return FSM, CSR update values,
// PC redirect and current privilege level.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int         XLEN       = 64,
    parameter logic [1:0] RESET_PRIV = 2'b11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [XLEN-1:0] pc_addr,
    input  logic            exc_en,
    input  logic [3:0]      exc_code,
    input  logic [XLEN-1:0] exc_val,
    input  logic            fetch_misaligned,
    input  logic            illegal_instr,
    input  logic [31:0]     instr_bits,
    input  logic            is_ebreak,
    input  logic            is_ecall,
    input  logic            is_mret,
    input  logic            ld_misaligned,
    input  logic            st_misaligned,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mstatus_current,
    input  logic [XLEN-1:0] mtvec_trap,
    input  logic [XLEN-1:0] mepc_current,
    input  logic [XLEN-1:0] mcause_current,
    input  logic [XLEN-1:0] mtval_current,
    output logic            trap_taken,
    output logic            trap_done,
    output logic [XLEN-1:0] mepc_next,
    output logic [XLEN-1:0] mcause_next,
    output logic [XLEN-1:0] mtval_next,
    output logic [XLEN-1:0] mstatus_next,
    output logic            pc_redirect_en,
    output logic [XLEN-1:0] pc_redirect,
    output logic            flush,
    output logic            busy,
    output logic [1:0]      priv_lvl
);

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    state_e          r_state;
    state_e          w_state_nxt;
    logic [1:0]      r_priv;
    logic [XLEN-1:0] r_pc;
    logic [3:0]      r_cause;
    logic [XLEN-1:0] r_tval;

    logic            w_sample;
    logic            w_exc;
    logic [3:0]      w_cause;
    logic [XLEN-1:0] w_tval;
    logic            w_take_exc;
    logic            w_take_ret;
    logic [1:0]      w_mpp;

    trap_prio_enc #(.XLEN(XLEN)) u_prio (
        .i_priv       (r_priv),
        .i_pc         (pc_addr),
        .i_exc_en     (exc_en),
        .i_exc_code   (exc_code),
        .i_exc_val    (exc_val),
        .i_fetch_mis  (fetch_misaligned),
        .i_illegal    (illegal_instr),
        .i_instr_bits (instr_bits),
        .i_ebreak     (is_ebreak),
        .i_ecall      (is_ecall),
        .i_mret       (is_mret),
        .i_ld_mis     (ld_misaligned),
        .i_st_mis     (st_misaligned),
        .i_mem_addr   (mem_addr),
        .o_valid      (w_exc),
        .o_cause      (w_cause),
        .o_tval       (w_tval)
    );

    assign w_sample   = instr_valid && (r_state == ST_IDLE);
    assign w_take_exc = w_sample && w_exc;
    assign w_take_ret = w_sample && !w_exc && is_mret && (r_priv == PRIV_M);
    assign w_mpp      = mstatus_current[MS_MPP_H:MS_MPP_L];
    assign priv_lvl   = r_priv;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_priv  <= RESET_PRIV;
            r_pc    <= '0;
            r_cause <= '0;
            r_tval  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take_exc) begin
                r_pc    <= pc_addr;
                r_cause <= w_cause;
                r_tval  <= w_tval;
            end
            if (r_state == ST_ENTER) begin
                r_priv <= PRIV_M;
            end else if (r_state == ST_RETURN) begin
                // reserved MPP encoding falls back to U
                r_priv <= (w_mpp == 2'b10) ? PRIV_U : w_mpp;
            end
        end
    end

    always_comb begin
        w_state_nxt    = ST_IDLE;
        trap_taken     = 1'b0;
        trap_done      = 1'b0;
        flush          = 1'b0;
        busy           = 1'b0;
        pc_redirect_en = 1'b0;
        pc_redirect    = '0;
        mepc_next      = '0;
        mcause_next    = '0;
        mtval_next     = '0;
        mstatus_next   = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_take_exc) begin
                    w_state_nxt = ST_ENTER;
                end else if (w_take_ret) begin
                    w_state_nxt = ST_RETURN;
                end
            end
            ST_ENTER: begin
                w_state_nxt  = ST_REDIRECT;
                trap_taken   = 1'b1;
                flush        = 1'b1;
                busy         = 1'b1;
                mepc_next    = r_pc & ALIGN_MASK;
                mcause_next  = {{(XLEN-4){1'b0}}, r_cause};
                mtval_next   = r_tval;
                mstatus_next = mstatus_current;
                mstatus_next[MS_MPIE] = mstatus_current[MS_MIE];
                mstatus_next[MS_MIE]  = 1'b0;
                mstatus_next[MS_MPP_H:MS_MPP_L] = r_priv;
            end
            ST_REDIRECT: begin
                busy           = 1'b1;
                pc_redirect_en = 1'b1;
                pc_redirect    = mtvec_trap & ALIGN_MASK;
            end
            ST_RETURN: begin
                trap_done      = 1'b1;
                flush          = 1'b1;
                busy           = 1'b1;
                pc_redirect_en = 1'b1;
                pc_redirect    = mepc_current & ALIGN_MASK;
                mepc_next      = mepc_current;
                mcause_next    = mcause_current;
                mtval_next     = mtval_current;
                mstatus_next   = mstatus_current;
                mstatus_next[MS_MIE]  = mstatus_current[MS_MPIE];
                mstatus_next[MS_MPIE] = 1'b1;
                mstatus_next[MS_MPP_H:MS_MPP_L] = PRIV_U;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule
